// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Defining MULT_RADIX4_EN retires two multiplier bits per BUSY cycle instead of one.
package mult_pkg;

    localparam int MULT_W = 32;
    localparam int CNT_W  = 6;

`ifdef MULT_RADIX4_EN
    localparam int STEP_COUNT = 16;
    localparam int STEP_SHIFT = 2;
`else
    localparam int STEP_COUNT = 32;
    localparam int STEP_SHIFT = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Magnitude of an operand; 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [MULT_W-1:0] absOperand(input logic [MULT_W-1:0] value,
                                                     input logic              isSigned);
        return (isSigned && value[MULT_W-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2 step: conditionally add the multiplicand into the upper half, then shift right by one
// with the carry entering the top bit.
module mult_step
    import mult_pkg::*;
(
    input  logic [2*MULT_W-1:0] acc_i,
    input  logic [MULT_W-1:0]   mcand_i,
    input  logic                mbit_i,
    output logic [2*MULT_W-1:0] acc_o
);

    logic [MULT_W:0] sum;

    assign sum   = {1'b0, acc_i[2*MULT_W-1:MULT_W]} + {1'b0, (mbit_i ? mcand_i : '0)};
    assign acc_o = {sum, acc_i[MULT_W-1:1]};

endmodule

// File: rtl/multiply.sv
// Fixed-latency 32x32 -> 64 shift-add multiplier supporting signed and unsigned operands.
// Defining MULT_RADIX4_EN chains two mult_step instances so that each BUSY cycle retires two multiplier bits.
module multiply
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                mult_begin,
    input  logic                mult_sign,
    input  logic [MULT_W-1:0]   mult_op1,
    input  logic [MULT_W-1:0]   mult_op2,
    output logic [2*MULT_W-1:0] product,
    output logic                mult_end
);

    state_t              state_q;
    logic [MULT_W-1:0]   mcand_q;
    logic [MULT_W-1:0]   mplier_q;
    logic [2*MULT_W-1:0] acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                negRes_q;
    logic [2*MULT_W-1:0] product_q;

    logic [2*MULT_W-1:0] acc_d;
    logic [2*MULT_W-1:0] product_d;

`ifdef MULT_RADIX4_EN
    logic [2*MULT_W-1:0] accMid;

    mult_step u_step0 (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .mbit_i  (mplier_q[0]),
        .acc_o   (accMid)
    );

    mult_step u_step1 (
        .acc_i   (accMid),
        .mcand_i (mcand_q),
        .mbit_i  (mplier_q[1]),
        .acc_o   (acc_d)
    );
`else
    mult_step u_step0 (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .mbit_i  (mplier_q[0]),
        .acc_o   (acc_d)
    );
`endif

    // The sign is restored on the magnitude only once, as the final step is written out.
    assign product_d = negRes_q ? -acc_d : acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            negRes_q  <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mult_begin) begin
                        mcand_q  <= absOperand(mult_op1, mult_sign);
                        mplier_q <= absOperand(mult_op2, mult_sign);
                        negRes_q <= mult_sign & (mult_op1[MULT_W-1] ^ mult_op2[MULT_W-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mult_begin) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_q >> STEP_SHIFT;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(STEP_COUNT - 1)) begin
                            product_q <= product_d;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign product  = product_q;
    assign mult_end = (state_q == DONE);

endmodule

// File: tb/tb_multiply.sv
// Self-checking bench for multiply: directed corner cases plus random operands against an arithmetic model.
// Build with MULT_RADIX4_EN defined to check the two-bit-per-cycle latency.
module tb_multiply;

`ifdef MULT_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        reset;
    logic        mult_begin;
    logic        mult_sign;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;

    int          checks;
    int          failures;
    logic [63:0] lastExp;

    multiply dut (
        .clk        (clk),
        .reset      (reset),
        .mult_begin (mult_begin),
        .mult_sign  (mult_sign),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain 64-bit multiply of sign- or zero-extended operands.
    function automatic logic [63:0] refMul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Starts at a negedge, leaves at the negedge after the DONE cycle; operands are scrambled after the load edge.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, input bit holdBegin);
        logic [63:0] expProd;
        int          cyc;
        expProd    = refMul(s, a, b);
        mult_begin = 1'b1;
        mult_sign  = s;
        mult_op1   = a;
        mult_op2   = b;
        cyc        = 0;
        do begin
            @(negedge clk);
            cyc++;
            mult_op1  = $urandom;
            mult_op2  = $urandom;
            mult_sign = 1'($urandom_range(0, 1));
        end while (!mult_end && cyc < LAT + 10);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(LAT + 1));
        checkOutput({tag, "_product"}, product, expProd);
        lastExp = expProd;
        if (!holdBegin) mult_begin = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_endwidth"}, 64'(mult_end), 64'(0));
        checkOutput({tag, "_hold"}, product, lastExp);
    endtask

    task automatic abortRun(input logic [31:0] a, input logic [31:0] b);
        bit sawEnd;
        mult_begin = 1'b1;
        mult_sign  = 1'b0;
        mult_op1   = a;
        mult_op2   = b;
        @(negedge clk);
        repeat (10) @(negedge clk);
        mult_begin = 1'b0;
        sawEnd = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (mult_end) sawEnd = 1'b1;
        end
        checkOutput("abort_noend", 64'(sawEnd), 64'(0));
        checkOutput("abort_product", product, lastExp);
    endtask

    task automatic resetMidRun(input logic [31:0] a, input logic [31:0] b);
        bit sawEnd;
        mult_begin = 1'b1;
        mult_sign  = 1'b1;
        mult_op1   = a;
        mult_op2   = b;
        @(negedge clk);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_product", product, 64'd0);
        checkOutput("midreset_end", 64'(mult_end), 64'(0));
        reset      = 1'b0;
        mult_begin = 1'b0;
        lastExp    = 64'd0;
        sawEnd     = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (mult_end) sawEnd = 1'b1;
        end
        checkOutput("midreset_idle", 64'(sawEnd), 64'(0));
        checkOutput("midreset_hold", product, 64'd0);
    endtask

    initial begin
        logic [31:0] edgeVals [6];
        checks     = 0;
        failures   = 0;
        lastExp    = 64'd0;
        reset      = 1'b1;
        mult_begin = 1'b1;
        mult_sign  = 1'b0;
        mult_op1   = 32'hFFFF_FFFF;
        mult_op2   = 32'hFFFF_FFFF;
        edgeVals   = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD};

        repeat (3) @(negedge clk);
        checkOutput("reset_product", product, 64'd0);
        checkOutput("reset_end", 64'(mult_end), 64'(0));
        reset = 1'b0;

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umax", 1'b0);
        checkOutput("umax_const", lastExp, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, "smin_smin", 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, "smin_one", 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, "neg3x7_s", 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, "neg3x7_u", 1'b0);

        applyStimulus(1'b1, 32'h1234_5678, 32'hFEDC_BA98, "b2b_first", 1'b1);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, "b2b_second", 1'b0);

        abortRun(32'h0BAD_F00D, 32'h1357_9BDF);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, "after_abort", 1'b0);

        resetMidRun(32'hCAFE_BABE, 32'h0000_0003);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, "after_reset", 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = (i % 4 == 0) ? edgeVals[$urandom_range(0, 5)] : $urandom;
            b = (i % 3 == 0) ? edgeVals[$urandom_range(0, 5)] : $urandom;
            applyStimulus(1'($urandom_range(0, 1)), a, b, "rand", (i != 23) && ($urandom_range(0, 1) == 1));
        end
        mult_begin = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiply.md
MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mult_begin  input  1  request; held high by the controller until mult_end is seen.
REQ-005 mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled at load.
REQ-006 mult_op1  input  32  multiplicand; sampled at load.
REQ-007 mult_op2  input  32  multiplier; sampled at load.
REQ-008 product  output  64  registered result, {HI, LO}.
REQ-009 mult_end  output  1  one-cycle completion pulse; product is valid while it is high.

Function
REQ-010 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-011 IDLE with mult_begin=1 at an edge (the load edge) SHALL latch the operand absolute values, the result sign (op1[31]^op2[31] when mult_sign=1, else 0), and clear the accumulator and iteration counter; the next state is BUSY.
REQ-012 Absolute value SHALL be taken only when mult_sign=1 and the operand's bit 31 is 1, as a 32-bit two's-complement negate; 0x80000000 yields unsigned 0x80000000.
REQ-013 Each BUSY edge SHALL perform one radix-2 shift-add step: if multiplier LSB=1, add multiplicand to accumulator[63:32] with carry; then shift {carry, accumulator} right 1 and multiplier right 1.
REQ-014 BUSY SHALL go to DONE on the edge completing the 32nd step; that same edge SHALL write product (the accumulator, two's-complement negated over 64 bits if the result sign is 1).
REQ-015 mult_end SHALL be 1 exactly while the state is DONE, decoded from the state register.
REQ-016 DONE SHALL go to IDLE on the next edge unconditionally.
REQ-017 Latency SHALL be fixed: mult_end is high in the cycle after edge L+32, where L is the load edge.
REQ-018 If mult_begin is still high in IDLE after DONE, a new operation SHALL load; controllers drop mult_begin on the cycle mult_end is seen.
REQ-019 mult_begin=0 at any BUSY edge SHALL abort: next state IDLE, no mult_end, product unchanged.
REQ-020 Operand and mult_sign changes after the load edge SHALL have no effect on the current operation.
REQ-021 product SHALL hold its value from DONE until the next completed operation.

Reset
REQ-022 reset=1 at an edge SHALL force state IDLE, product=0, mult_end=0, and clear the counter and accumulator, overriding all other inputs, including mid-operation.
REQ-023 The first load SHALL be possible on the first edge with reset=0.

Configuration
REQ-024 Macro MULT_RADIX4_EN SHALL select the step width.
- Defined: each BUSY edge performs two shift-add steps (two chained adders, multiplier LSBs [0] then [1], shift by 2); DONE is entered after 16 steps, so mult_end is high in the cycle after edge L+16.
- Undefined: radix-2 behaviour and 32-step latency per REQ-013 and REQ-017.
- Results SHALL be bit-identical in both builds.

Structure
REQ-025 Package mult_pkg SHALL hold the state enum (IDLE/BUSY/DONE), MULT_W=32 and the step count (32, or 16 when MULT_RADIX4_EN is defined).
REQ-026 Sub-module mult_step SHALL implement one conditional-add-and-shift step (inputs: accumulator, multiplicand, multiplier bit; output: next accumulator), instantiated once, or twice chained under MULT_RADIX4_EN.

Verification
REQ-027 Unsigned 0xFFFFFFFF x 0xFFFFFFFF, mult_sign=0 -> product 0xFFFFFFFE00000001, mult_end at L+33 (L+17 radix-4), one cycle wide.
REQ-028 Signed 0x80000000 x 0x80000000 -> 0x4000000000000000; signed 0x80000000 x 0x00000001 -> 0xFFFFFFFF80000000.
REQ-029 Signed 0xFFFFFFFD (-3) x 0x00000007 -> 0xFFFFFFFFFFFFFFEB; then unsigned on the same operands -> 0x00000006FFFFFFEB.
REQ-030 Drop mult_begin at BUSY step 10 -> no mult_end, product keeps the prior value; a new request completes correctly.
REQ-031 Assert reset during BUSY -> next cycle state IDLE, product=0, mult_end=0; change operands mid-BUSY on a normal run -> result uses the loaded values.
REQ-032 Hold mult_begin high through DONE -> a second back-to-back operation loads on the IDLE edge and completes with the same latency.
